axi_console_snoop: RTL and testbench

AXI_CONSOLE_SNOOP -- requirements
Module: axi_console_snoop

---
 rtl/axi_console_snoop.sv | 230 +++++++++++++++++++++++
 tb/tb_axi_console_snoop.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_console_snoop.sv
// Passive AXI write snooper: console bytes, retire watchdog, pass/fail magic.
// Never drives the bus; every status flag is sticky until rst.
module axi_console_snoop #(
  parameter logic [31:0] CONSOLE_ADDR = 32'h10015000,
  parameter int          WINDOW       = 50000,
  parameter int          CHAR_DEPTH   = 16,
  parameter int          AWQ_DEPTH    = 4,
  parameter logic [63:0] PASS_MAGIC   = 64'h444333222,
  parameter logic [63:0] FAIL_MAGIC   = 64'h2382348720
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         awvalid,
  input  logic         awready,
  input  logic [39:0]  awaddr,
  input  logic [3:0]   awlen,
  input  logic         wvalid,
  input  logic         wready,
  input  logic         wlast,
  input  logic [127:0] wdata,
  input  logic [15:0]  wstrb,
  input  logic         retire,
  input  logic [63:0]  wb0_data,
  input  logic [63:0]  wb1_data,
  output logic [7:0]   con_char,
  output logic         con_valid,
  input  logic         con_ready,
  output logic         char_ovf,
  output logic         proto_err,
  output logic         hang,
  output logic         sim_pass,
  output logic         sim_fail
);

  localparam int QW = (AWQ_DEPTH > 1) ? $clog2(AWQ_DEPTH) : 1;
  localparam int CW = $clog2(AWQ_DEPTH + 1);
  localparam int FW = $clog2(CHAR_DEPTH);
  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  logic                 aw_hs;
  logic                 w_hs;
  logic                 aw_con;
  logic                 q_empty;
  logic                 q_full;
  logic                 w_con;
  logic                 w_ok;
  logic                 w_orphan;
  logic                 q_pop;
  logic                 q_push_req;
  logic                 q_push;
  logic                 q_drop;
  logic [AWQ_DEPTH-1:0] awq;
  logic [QW-1:0]        q_rd;
  logic [QW-1:0]        q_wr;
  logic [CW-1:0]        q_cnt;

  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  assign aw_con  = (awaddr[31:0] == CONSOLE_ADDR)
                 && (awlen == 4'd0);
  assign q_empty = (q_cnt == '0);
  assign q_full  = (q_cnt == CW'(AWQ_DEPTH));

  // empty queue + same-cycle AW: the beat rides the incoming entry
  assign w_con      = q_empty ? aw_con : awq[q_rd];
  assign w_ok       = w_hs & (~q_empty | aw_hs);
  assign w_orphan   = w_hs & q_empty & ~aw_hs;
  assign q_pop      = w_ok & wlast & ~q_empty;
  assign q_push_req = aw_hs & ~(q_empty & w_hs & wlast);
  assign q_drop     = q_push_req & q_full & ~q_pop;
  assign q_push     = q_push_req & ~q_drop;

  function automatic logic [QW-1:0] q_nxt(
    input logic [QW-1:0] p
  );
    return (p == QW'(AWQ_DEPTH - 1)) ? '0 : p + QW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awq   <= '0;
      q_rd  <= '0;
      q_wr  <= '0;
      q_cnt <= '0;
    end else begin
      if (q_push) begin
        awq[q_wr] <= aw_con;
        q_wr      <= q_nxt(q_wr);
      end
      if (q_pop)
        q_rd <= q_nxt(q_rd);
      unique case ({q_push, q_pop})
        2'b10:   q_cnt <= q_cnt + CW'(1);
        2'b01:   q_cnt <= q_cnt - CW'(1);
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  logic       sel_v;
  logic [7:0] sel_b;

  always_comb begin
    sel_v = 1'b0;
    sel_b = 8'h00;
    unique case (1'b1)
      wstrb == 16'h000f: begin
        sel_v = 1'b1;
        sel_b = wdata[7:0];
      end
      wstrb == 16'h00f0: begin
        sel_v = 1'b1;
        sel_b = wdata[39:32];
      end
      wstrb == 16'h0f00: begin
        sel_v = 1'b1;
        sel_b = wdata[71:64];
      end
      wstrb == 16'hf000: begin
        sel_v = 1'b1;
        sel_b = wdata[103:96];
      end
      default: ;
    endcase
  end

  logic       byte_v;
  logic [7:0] byte_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_v <= 1'b0;
      byte_d <= 8'h00;
    end else begin
      byte_v <= w_ok & w_con & sel_v;
      byte_d <= sel_b;
    end
  end

  logic [7:0]  mem [CHAR_DEPTH];
  logic [FW:0] f_rd;
  logic [FW:0] f_wr;
  logic        f_empty;
  logic        f_full;
  logic        f_pop;
  logic        f_push;
  logic        f_ovf;

  assign f_empty = (f_rd == f_wr);
  assign f_full  = (f_rd[FW] != f_wr[FW])
                 && (f_rd[FW-1:0] == f_wr[FW-1:0]);
  assign f_pop   = con_valid & con_ready;
  assign f_push  = byte_v & (~f_full | f_pop);
  assign f_ovf   = byte_v & f_full & ~f_pop;

  assign con_valid = ~f_empty;
  assign con_char  = f_empty ? 8'h00 : mem[f_rd[FW-1:0]];

  always_ff @(posedge clk) begin
    if (f_push)
      mem[f_wr[FW-1:0]] <= byte_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_rd <= '0;
      f_wr <= '0;
    end else begin
      if (f_push)
        f_wr <= f_wr + 1'b1;
      if (f_pop)
        f_rd <= f_rd + 1'b1;
    end
  end

  logic [WW-1:0] win_cnt;
  logic          seen;
  logic          win_end;

  assign win_end = (win_cnt == WW'(WINDOW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt <= '0;
      seen    <= 1'b0;
    end else begin
      win_cnt <= win_end ? '0 : win_cnt + WW'(1);
      seen    <= win_end ? 1'b0 : (seen | retire);
    end
  end

  logic [63:0] wb0_q;
  logic [63:0] wb1_q;
  logic        pass_hit;
  logic        fail_hit;

  assign pass_hit = (wb0_q == PASS_MAGIC)
                  | (wb1_q == PASS_MAGIC);
  assign fail_hit = (wb0_q == FAIL_MAGIC)
                  | (wb1_q == FAIL_MAGIC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb0_q <= '0;
      wb1_q <= '0;
    end else begin
      wb0_q <= wb0_data;
      wb1_q <= wb1_data;
    end
  end

  // fail wins a same-cycle tie; whichever lands first locks out the other
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_ovf  <= 1'b0;
      proto_err <= 1'b0;
      hang      <= 1'b0;
      sim_pass  <= 1'b0;
      sim_fail  <= 1'b0;
    end else begin
      char_ovf  <= char_ovf | f_ovf;
      proto_err <= proto_err | w_orphan | q_drop;
      hang      <= hang | (win_end & ~seen & ~retire);
      sim_fail  <= sim_fail | (fail_hit & ~sim_pass);
      sim_pass  <= sim_pass
                 | (pass_hit & ~fail_hit & ~sim_fail);
    end
  end

endmodule

// File: tb/tb_axi_console_snoop.sv
// Bench for axi_console_snoop: byte scoreboard plus flag and
// watchdog checks.
module tb_axi_console_snoop;

  localparam logic [31:0] CON  = 32'h10015000;
  localparam logic [63:0] PASS = 64'h444333222;
  localparam logic [63:0] FAIL_M = 64'h2382348720;

  logic         clk;
  logic         rst;
  logic         awvalid;
  logic         awready;
  logic [39:0]  awaddr;
  logic [3:0]   awlen;
  logic         wvalid;
  logic         wready;
  logic         wlast;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         retire;
  logic [63:0]  wb0_data;
  logic [63:0]  wb1_data;
  logic [7:0]   con_char;
  logic         con_valid;
  logic         con_ready;
  logic         char_ovf;
  logic         proto_err;
  logic         hang;
  logic         sim_pass;
  logic         sim_fail;

  int errs;
  int checks;
  logic [7:0] sb [$];

  axi_console_snoop #(.WINDOW(100)) dut (
    .clk       (clk),
    .rst       (rst),
    .awvalid   (awvalid),
    .awready   (awready),
    .awaddr    (awaddr),
    .awlen     (awlen),
    .wvalid    (wvalid),
    .wready    (wready),
    .wlast     (wlast),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .retire    (retire),
    .wb0_data  (wb0_data),
    .wb1_data  (wb1_data),
    .con_char  (con_char),
    .con_valid (con_valid),
    .con_ready (con_ready),
    .char_ovf  (char_ovf),
    .proto_err (proto_err),
    .hang      (hang),
    .sim_pass  (sim_pass),
    .sim_fail  (sim_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {char_ovf, proto_err, hang, sim_pass, sim_fail};
  endfunction

  // consumed bytes are compared in order against the scoreboard
  always @(negedge clk) begin
    if (!rst && con_valid && con_ready) begin
      chk("sb_has", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0)
        chk("con_char", 64'(con_char), 64'(sb.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] lane(
    input logic [15:0] s,
    input logic [7:0]  b
  );
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    case (s)
      16'h000f: d[7:0]    = b;
      16'h00f0: d[39:32]  = b;
      16'h0f00: d[71:64]  = b;
      16'hf000: d[103:96] = b;
      default:  ;
    endcase
    return d;
  endfunction

  task automatic drive(
    input bit          do_aw,
    input logic [39:0] a,
    input logic [3:0]  l,
    input bit          do_w,
    input logic [15:0] s,
    input logic [7:0]  b,
    input bit          last
  );
    awvalid = do_aw;
    awaddr  = a;
    awlen   = l;
    wvalid  = do_w;
    wstrb   = s;
    wdata   = lane(s, b);
    wlast   = last;
    step();
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  task automatic con_wr(
    input logic [7:0] b,
    input bit         exp_out
  );
    if (exp_out)
      sb.push_back(b);
    drive(1, {8'hab, CON}, 0, 1, 16'h000f, b, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && sb.size() != 0; i++)
      step();
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    errs      = 0;
    checks    = 0;
    rst       = 1'b1;
    awvalid   = 1'b0;
    awready   = 1'b1;
    awaddr    = '0;
    awlen     = '0;
    wvalid    = 1'b0;
    wready    = 1'b1;
    wlast     = 1'b0;
    wdata     = '0;
    wstrb     = '0;
    retire    = 1'b1;
    wb0_data  = '0;
    wb1_data  = '0;
    con_ready = 1'b1;
    step();
    chk("rst_valid", 64'(con_valid), 64'd0);
    chk("rst_char", 64'(con_char), 64'd0);
    chk("rst_flags", 64'(flags()), 64'd0);
    rst = 1'b0;
    step();

    // AW then W, byte in lane 4
    drive(1, {8'h00, CON}, 0, 0, 0, 0, 0);
    sb.push_back(8'h41);
    drive(0, 0, 0, 1, 16'h00f0, 8'h41, 1);
    chk("lat_c1", 64'(con_valid), 64'd0);
    step();
    chk("lat_c2", 64'(con_valid), 64'd1);
    drain("drain_basic");
    chk("basic_flags", 64'(flags()), 64'd0);

    // same-cycle AW+W bypass, lane 12
    sb.push_back(8'h0a);
    drive(1, {8'h00, CON}, 0, 1, 16'hf000, 8'h0a, 1);
    drain("drain_bypass");

    // other strobes give nothing; other lanes give their byte
    drive(1, {8'h00, CON}, 0, 1, 16'hffff, 8'h77, 1);
    sb.push_back(8'h33);
    drive(1, {8'h00, CON}, 0, 1, 16'h0f00, 8'h33, 1);
    drain("drain_lanes");

    // 4-beat burst elsewhere, then one console byte
    drive(1, 40'h0080000000, 3, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      drive(0, 0, 0, 1, 16'h000f, 8'h90 + 8'(i), i == 3);
    con_wr(8'h42, 1);
    drain("drain_burst");

    // burst on console address with awlen!=0 is not console
    drive(1, {8'h00, CON}, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 16'h000f, 8'h91, 0);
    drive(0, 0, 0, 1, 16'h000f, 8'h92, 1);

    // two queued AWs served in order
    drive(1, {8'h00, CON}, 0, 0, 0, 0, 0);
    drive(1, 40'h0000001000, 0, 0, 0, 0, 0);
    drive(1, {8'h00, CON}, 0, 0, 0, 0, 0);
    sb.push_back(8'h43);
    drive(0, 0, 0, 1, 16'h000f, 8'h43, 1);
    drive(0, 0, 0, 1, 16'h000f, 8'h55, 1);
    sb.push_back(8'h44);
    drive(0, 0, 0, 1, 16'h000f, 8'h44, 1);
    drain("drain_queue");
    chk("queue_flags", 64'(flags()), 64'd0);

    // 17 bytes with the consumer stalled
    con_ready = 1'b0;
    for (int i = 0; i < 17; i++)
      con_wr(8'h60 + 8'(i), i < 16);
    step();
    step();
    chk("ovf_set", 64'(char_ovf), 64'd1);
    chk("ovf_head", 64'(con_char), 64'(sb[0]));
    step();
    chk("ovf_hold", 64'(con_char), 64'h60);
    con_ready = 1'b1;
    drain("drain_ovf");
    step();
    chk("ovf_empty", 64'(con_valid), 64'd0);
    chk("ovf_sticky", 64'(char_ovf), 64'd1);

    // pass magic then fail magic
    do_reset();
    wb1_data = PASS;
    step();
    wb1_data = '0;
    chk("pass_c1", 64'(sim_pass), 64'd0);
    step();
    chk("pass_c2", 64'(sim_pass), 64'd1);
    wb0_data = FAIL_M;
    step();
    wb0_data = '0;
    step();
    step();
    chk("pass_keep", 64'(sim_pass), 64'd1);
    chk("fail_lock", 64'(sim_fail), 64'd0);

    // same-cycle pass and fail
    do_reset();
    wb0_data = PASS;
    wb1_data = FAIL_M;
    step();
    wb0_data = '0;
    wb1_data = '0;
    step();
    chk("tie_fail", 64'(sim_fail), 64'd1);
    chk("tie_pass", 64'(sim_pass), 64'd0);

    // orphan W beat
    do_reset();
    drive(0, 0, 0, 1, 16'h000f, 8'h21, 1);
    chk("orphan_err", 64'(proto_err), 64'd1);
    step();
    step();
    chk("orphan_nobyte", 64'(con_valid), 64'd0);

    // AW queue overflow; full push+pop is legal
    do_reset();
    for (int i = 0; i < 4; i++)
      drive(1, 40'h1000, 0, 0, 0, 0, 0);
    chk("awq_full_ok", 64'(proto_err), 64'd0);
    drive(1, 40'h1000, 0, 1, 16'h000f, 8'h00, 1);
    chk("awq_pushpop", 64'(proto_err), 64'd0);
    drive(1, 40'h1000, 0, 0, 0, 0, 0);
    chk("awq_drop", 64'(proto_err), 64'd1);

    // reset mid-transaction discards queue and bytes
    do_reset();
    con_ready = 1'b0;
    con_wr(8'h55, 0);
    drive(1, {8'h00, CON}, 0, 0, 0, 0, 0);
    step();
    chk("pre_rst_valid", 64'(con_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(con_valid), 64'd0);
    chk("mid_rst_char", 64'(con_char), 64'd0);
    chk("mid_rst_flags", 64'(flags()), 64'd0);
    step();
    rst = 1'b0;
    con_ready = 1'b1;
    drive(0, 0, 0, 1, 16'h000f, 8'h66, 1);
    chk("post_rst_err", 64'(proto_err), 64'd1);
    step();
    step();
    chk("post_rst_empty", 64'(con_valid), 64'd0);

    // watchdog without retire
    retire = 1'b0;
    do_reset();
    for (int i = 0; i < 99; i++)
      step();
    chk("hang_early", 64'(hang), 64'd0);
    step();
    step();
    chk("hang_set", 64'(hang), 64'd1);
    for (int i = 0; i < 150; i++)
      step();
    chk("hang_sticky", 64'(hang), 64'd1);

    // one retire per window keeps hang clear
    do_reset();
    for (int i = 0; i < 500; i++) begin
      retire = (i % 100) == 50;
      step();
    end
    retire = 1'b0;
    chk("hang_clear", 64'(hang), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
